// File: rtl/mips_mem_pkg.sv
// Shared types for the MEM-stage load/store path:
// access size codes, controller state encoding and data width.
package mips_mem_pkg;

  localparam int LEN_DATA = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD_A = 2'b01,
    RD_D = 2'b10,
    WR   = 2'b11
  } state_e;

  // Size code illegal, or address not aligned to the access size.
  function automatic logic bad_align(size_e sz, logic [1:0] off);
    logic r;
    r = 1'b0;
    unique case (sz)
      SZ_HALF: r = off[0];
      SZ_WORD: r = (off != 2'b00);
      SZ_BAD:  r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response and data-memory port bundle
// of the MEM-stage load/store controller.
interface mem_access_unit_if #(
  parameter int len_addr = 32,
  parameter int len_data = 32
);
  logic                req_rd;
  logic                req_wr;
  logic [1:0]          req_size;
  logic                req_signed;
  logic [len_addr-1:0] req_addr;
  logic [len_data-1:0] req_wdata;
  logic                stall;
  logic                done;
  logic [len_data-1:0] load_data;
  logic                addr_err;
  logic                mem_rd;
  logic                mem_wr;
  logic [len_addr-1:0] mem_addr;
  logic [len_data-1:0] mem_wdata;
  logic [len_data-1:0] mem_rdata;

  modport master (
    output req_rd, req_wr, req_size, req_signed,
    output req_addr, req_wdata, mem_rdata,
    input  stall, done, load_data, addr_err,
    input  mem_rd, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    input  req_rd, req_wr, req_size, req_signed,
    input  req_addr, req_wdata, mem_rdata,
    output stall, done, load_data, addr_err,
    output mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lane_align.sv
// Byte/half lane extract with sign/zero extension for loads,
// and lane merge into a read word for sub-word stores.
module lane_align
  import mips_mem_pkg::*;
(
  input  logic [LEN_DATA-1:0] word,
  input  size_e               size,
  input  logic                sgn,
  input  logic [1:0]          off,
  input  logic [LEN_DATA-1:0] wdata,
  output logic [LEN_DATA-1:0] load_val,
  output logic [LEN_DATA-1:0] merged
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b        = word[{off, 3'b000} +: 8];
    h        = off[1] ? word[31:16] : word[15:0];
    load_val = word;
    merged   = word;
    unique case (1'b1)
      (size == SZ_BYTE): begin
        load_val = {{24{sgn & b[7]}}, b};
        merged[{off, 3'b000} +: 8] = wdata[7:0];
      end
      (size == SZ_HALF): begin
        load_val = {{16{sgn & h[15]}}, h};
        if (off[1]) merged[31:16] = wdata[15:0];
        else        merged[15:0]  = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: word memory cycles,
// read-modify-write for sub-word stores, pipeline stall.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int len_addr  = 32,
  parameter int len_data  = 32,
  parameter int ram_depth = 2048
) (
  input logic             clk,
  input logic             reset_n,
  mem_access_unit_if.slave bus
);

  localparam int IW = len_addr - 2;
  localparam logic [IW-1:0] DEPTH = IW'(ram_depth);

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q;
  logic [1:0]          off_q;
  size_e               size_q;
  logic                sgn_q;
  logic                ld_q;
  logic [len_data-1:0] wdata_q;
  logic [len_data-1:0] merged_q;
  logic [len_data-1:0] load_q;
  logic                done_q, err_q;

  logic                done_d, err_d;
  logic                lat_en, load_en, merge_en;
  logic                stall, mem_rd, mem_wr;
  logic [IW-1:0]       idx;
  logic [len_data-1:0] mem_wdata;
  logic [IW-1:0]       req_idx;
  logic                req_any, bad;
  logic [len_data-1:0] load_val, merged;

  assign req_idx = bus.req_addr[len_addr-1:2];
  assign req_any = bus.req_rd | bus.req_wr;
  assign bad     = (bus.req_rd & bus.req_wr)
                 | bad_align(size_e'(bus.req_size),
                             bus.req_addr[1:0])
                 | (req_idx >= DEPTH);

  lane_align u_lane (
    .word     (bus.mem_rdata),
    .size     (size_q),
    .sgn      (sgn_q),
    .off      (off_q),
    .wdata    (wdata_q),
    .load_val (load_val),
    .merged   (merged)
  );

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    idx       = idx_q;
    mem_wdata = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    lat_en    = 1'b0;
    load_en   = 1'b0;
    merge_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_any) begin
          if (bad) begin
            err_d = 1'b1;
          end else if (bus.req_wr &&
                       bus.req_size == SZ_WORD) begin
            mem_wr    = 1'b1;
            idx       = req_idx;
            mem_wdata = bus.req_wdata;
            done_d    = 1'b1;
          end else begin
            mem_rd  = 1'b1;
            idx     = req_idx;
            stall   = 1'b1;
            lat_en  = 1'b1;
            state_d = RD_A;
          end
        end
      end
      RD_A: begin
        mem_rd  = 1'b1;
        stall   = 1'b1;
        state_d = RD_D;
      end
      RD_D: begin
        if (ld_q) begin
          load_en = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          merge_en = 1'b1;
          stall    = 1'b1;
          state_d  = WR;
        end
      end
      WR: begin
        mem_wr    = 1'b1;
        mem_wdata = merged_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
    endcase
    // Memory strobes must fall with reset, not wait for a clock.
    if (!reset_n) begin
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      stall  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      off_q    <= '0;
      size_q   <= SZ_BYTE;
      sgn_q    <= 1'b0;
      ld_q     <= 1'b0;
      wdata_q  <= '0;
      merged_q <= '0;
      load_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (lat_en) begin
        idx_q   <= req_idx;
        off_q   <= bus.req_addr[1:0];
        size_q  <= size_e'(bus.req_size);
        sgn_q   <= bus.req_signed;
        ld_q    <= bus.req_rd;
        wdata_q <= bus.req_wdata;
      end
      if (load_en)  load_q   <= load_val;
      if (merge_en) merged_q <= merged;
    end
  end

  assign bus.stall     = stall;
  assign bus.done      = done_q;
  assign bus.addr_err  = err_q;
  assign bus.load_data = load_q;
  assign bus.mem_rd    = mem_rd;
  assign bus.mem_wr    = mem_wr;
  assign bus.mem_addr  = {2'b00, idx};
  assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, reset abort,
// back-to-back sequence and random traffic against a model.
module tb_mem_access_unit;
  import mips_mem_pkg::*;

  typedef struct {
    bit        rd, wr;
    bit [1:0]  sz;
    bit        sg;
    bit [31:0] ad, wd;
    bit        err;
    bit [31:0] ld;
    bit [7:0]  pat;
    int        plen, wrs;
    bit        cm;
    bit [31:0] cw;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Word memory: address taken at posedge, data one posedge later.
  logic [31:0] mem [0:2047];
  bit   [10:0] a1;
  logic [31:0] rdata;
  bit          inited;
  assign bus.mem_rdata = rdata;

  always @(posedge clk) begin
    rdata <= mem[a1];
    if (bus.mem_rd) a1 <= bus.mem_addr[10:0];
  end

  always @(negedge clk) begin
    if (!inited) begin
      for (int i = 0; i < 2048; i++) mem[i] <= '0;
      inited <= 1'b1;
    end else if (bus.mem_wr) begin
      mem[bus.mem_addr[10:0]] <= bus.mem_wdata;
    end
  end

  int done_cnt = 0, err_cnt = 0, wr_cyc = 0;
  bit both = 0;
  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.addr_err) err_cnt++;
    if (bus.mem_wr) wr_cyc++;
    if (bus.done && bus.addr_err) both = 1;
    if (bus.mem_wr && bus.mem_rd) both = 1;
  end

  int n_run = 0, n_fail = 0, exp_errs = 0;
  bit [31:0] ref_mem [0:2047];
  bit [31:0] last_ld = 0;
  vec_t tbl [21];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: expected response straight from the access rules.
  task automatic model(input bit rd, input bit wr,
                       input bit [1:0] sz, input bit sg,
                       input bit [31:0] ad, input bit [31:0] wd,
                       output vec_t v);
    int unsigned idx, o;
    bit [31:0] x, m;
    idx = ad / 4;
    o = ad % 4;
    v.rd = rd; v.wr = wr; v.sz = sz; v.sg = sg;
    v.ad = ad; v.wd = wd;
    v.err = (rd && wr) || sz == 3 || idx >= 2048
         || (sz == 1 && o % 2 == 1) || (sz == 2 && o != 0);
    v.ld = last_ld; v.pat = 0; v.plen = 1; v.wrs = 0;
    v.cm = 0; v.cw = 0;
    if (v.err) return;
    if (rd) begin
      x = ref_mem[idx] >> (8 * o);
      if (sz == 0) begin
        x = x & 'hFF;
        if (sg && x >= 'h80) x = x - 'h100;
      end else if (sz == 1) begin
        x = x & 'hFFFF;
        if (sg && x >= 'h8000) x = x - 'h10000;
      end
      last_ld = x;
      v.ld = x; v.pat = 8'd6; v.plen = 3;
    end else begin
      m = (sz == 2) ? 32'hFFFF_FFFF
        : (sz == 1) ? 32'h0000_FFFF : 32'h0000_00FF;
      m = m << (8 * o);
      ref_mem[idx] = (ref_mem[idx] & ~m) | ((wd << (8 * o)) & m);
      v.wrs = 1; v.cm = 1; v.cw = ref_mem[idx];
      if (sz != 2) begin v.pat = 8'd14; v.plen = 4; end
    end
  endtask

  // Drive one request and follow it until done/addr_err.
  task automatic access(input string nm, input vec_t v);
    bit gd, ge;
    bit [7:0] pat;
    int plen, wrs, rds;
    bus.req_rd = v.rd; bus.req_wr = v.wr;
    bus.req_size = v.sz; bus.req_signed = v.sg;
    bus.req_addr = v.ad; bus.req_wdata = v.wd;
    gd = 0; ge = 0; pat = 0; plen = 0; wrs = 0; rds = 0;
    for (int k = 0; k < 8 && !gd && !ge; k++) begin
      @(negedge clk);
      pat = {pat[6:0], bus.stall};
      plen++;
      wrs += int'(bus.mem_wr);
      rds += int'(bus.mem_rd);
      @(posedge clk); #1;
      gd = bus.done; ge = bus.addr_err;
    end
    bus.req_rd = 0; bus.req_wr = 0;
    if (v.err) exp_errs++;
    chk({nm, " outcome"}, {30'd0, ge, gd},
        v.err ? 32'd2 : 32'd1);
    chk({nm, " stall"}, {24'd0, pat}, {24'd0, v.pat});
    chk({nm, " cycles"}, 32'(plen), 32'(v.plen));
    chk({nm, " writes"}, 32'(wrs), 32'(v.wrs));
    if (v.err) chk({nm, " reads"}, 32'(rds), 32'd0);
    chk({nm, " load_data"}, bus.load_data, v.ld);
    if (v.cm) chk({nm, " mem"}, mem[v.ad[12:2]], v.cw);
  endtask

  task automatic mrun(input string nm, input bit rd,
                      input bit wr, input bit [1:0] sz,
                      input bit sg, input bit [31:0] ad,
                      input bit [31:0] wd);
    vec_t v;
    model(rd, wr, sz, sg, ad, wd, v);
    access(nm, v);
  endtask

  initial begin
    vec_t mv;
    int w0, d0;
    bit rd, wr, sg;
    bit [1:0] sz;
    bit [31:0] ad;
    for (int i = 0; i < 2048; i++) ref_mem[i] = '0;

    //        rd wr sz sg addr  wdata  err ld pat len wr cm word
    tbl[0]  = '{0,1,2,0,'h10,'hDEADBEEF,0,'h0,0,1,1,1,'hDEADBEEF};
    tbl[1]  = '{1,0,2,0,'h10,0,0,'hDEADBEEF,6,3,0,0,0};
    tbl[2]  = '{0,1,2,0,'h10,'h11223344,0,'hDEADBEEF,0,1,1,1,
                'h11223344};
    tbl[3]  = '{0,1,0,0,'h13,'h123456A5,0,'hDEADBEEF,14,4,1,1,
                'hA5223344};
    tbl[4]  = '{1,0,0,1,'h13,0,0,'hFFFFFFA5,6,3,0,0,0};
    tbl[5]  = '{1,0,0,0,'h13,0,0,'h000000A5,6,3,0,0,0};
    tbl[6]  = '{1,0,0,1,'h11,0,0,'h00000033,6,3,0,0,0};
    tbl[7]  = '{0,1,2,0,'h10,'h80001234,0,'h33,0,1,1,1,
                'h80001234};
    tbl[8]  = '{1,0,1,1,'h12,0,0,'hFFFF8000,6,3,0,0,0};
    tbl[9]  = '{1,0,1,0,'h12,0,0,'h00008000,6,3,0,0,0};
    tbl[10] = '{1,0,1,1,'h10,0,0,'h00001234,6,3,0,0,0};
    tbl[11] = '{0,1,1,0,'h12,'hFFFF7E5A,0,'h1234,14,4,1,1,
                'h7E5A1234};
    tbl[12] = '{1,0,0,0,'h12,0,0,'h5A,6,3,0,0,0};
    tbl[13] = '{1,0,2,0,'h06,0,1,'h5A,0,1,0,0,0};
    tbl[14] = '{1,0,1,0,'h01,0,1,'h5A,0,1,0,0,0};
    tbl[15] = '{1,0,3,0,'h20,0,1,'h5A,0,1,0,0,0};
    tbl[16] = '{1,0,2,0,'h2000,0,1,'h5A,0,1,0,0,0};
    tbl[17] = '{1,1,2,0,'h20,0,1,'h5A,0,1,0,0,0};
    tbl[18] = '{0,1,0,0,'h14,'hFFFFFF77,0,'h5A,14,4,1,1,
                'h00000077};
    tbl[19] = '{1,0,0,1,'h14,0,0,'h77,6,3,0,0,0};
    tbl[20] = '{1,0,2,0,'h1FFC,0,0,'h0,6,3,0,0,0};

    // Reset with a request present: nothing may leak out.
    bus.req_rd = 1; bus.req_wr = 0; bus.req_size = 2;
    bus.req_signed = 0; bus.req_addr = 0; bus.req_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset mem_rd", 32'(bus.mem_rd), 0);
    chk("reset mem_wr", 32'(bus.mem_wr), 0);
    chk("reset stall", 32'(bus.stall), 0);
    chk("reset done", 32'(bus.done), 0);
    chk("reset addr_err", 32'(bus.addr_err), 0);
    chk("reset load_data", bus.load_data, 0);
    bus.req_rd = 0;
    @(negedge clk);
    reset_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 21; i++) begin
      model(tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].sg,
            tbl[i].ad, tbl[i].wd, mv);
      access($sformatf("vec%0d", i), tbl[i]);
    end

    // Reset during RD_D of a half store aborts it cleanly.
    mrun("sw40", 0, 1, 2, 0, 'h40, 'hCAFEF00D);
    w0 = wr_cyc;
    bus.req_rd = 0; bus.req_wr = 1; bus.req_size = 1;
    bus.req_signed = 0; bus.req_addr = 'h42;
    bus.req_wdata = 'h1111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort stall rd_d", 32'(bus.stall), 1);
    reset_n = 0;
    #1;
    chk("abort mem_wr", 32'(bus.mem_wr), 0);
    chk("abort mem_rd", 32'(bus.mem_rd), 0);
    chk("abort stall", 32'(bus.stall), 0);
    chk("abort load_data", bus.load_data, 0);
    bus.req_wr = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    @(posedge clk); #1;
    chk("abort no write", 32'(wr_cyc - w0), 0);
    chk("abort word kept", mem[16], 'hCAFEF00D);
    last_ld = 0;
    mrun("post-abort lw", 1, 0, 2, 0, 'h40, 0);
    chk("post-abort value", bus.load_data, 'hCAFEF00D);

    // Back-to-back LW, SH, LW with no idle gap.
    @(posedge clk); #1;
    d0 = done_cnt;
    mrun("b2b lw1", 1, 0, 2, 0, 'h40, 0);
    mrun("b2b sh", 0, 1, 1, 0, 'h40, 'h0000BEEF);
    mrun("b2b lw2", 1, 0, 2, 0, 'h40, 0);
    chk("b2b value", bus.load_data, 'hCAFEBEEF);
    @(posedge clk); #1;
    chk("b2b done count", 32'(done_cnt - d0), 3);

    for (int i = 0; i < 200; i++) begin
      int r;
      r = $urandom_range(0, 99);
      rd = (r < 50);
      wr = !rd;
      if (r >= 95) begin rd = 1; wr = 1; end
      sz = ($urandom_range(0, 19) == 0) ? 2'd3
         : 2'($urandom_range(0, 2));
      sg = 1'($urandom_range(0, 1));
      ad = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0)
        ad = ad & ((sz == 2) ? ~32'd3 : ~32'd1);
      if ($urandom_range(0, 24) == 0)
        ad = 32'h2000 + 32'($urandom_range(0, 'hFFF));
      mrun($sformatf("rnd%0d", i), rd, wr, sz, sg, ad,
           $urandom);
    end

    @(posedge clk); #1;
    chk("done/err overlap or rd+wr", 32'(both), 0);
    chk("addr_err pulses", 32'(err_cnt), 32'(exp_errs));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
